core_dcache_way_array: RTL and testbench

CORE_DCACHE_WAY_ARRAY -- requirements
Module: core_dcache_way_array

---
 rtl/core_dcache_pkg.sv | 43 ++++
 rtl/core_dcache_plru.sv | 76 +++++++
 rtl/core_dcache_way_array.sv | 156 +++++++++++++++
 tb/tb_core_dcache_way_array.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_dcache_pkg.sv
// Shared types and address-field helpers for the data-cache way array.
package core_dcache_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_D = 2'b11
    } size_e;

    localparam int BYTE_OFF_LSB = 0;
    localparam int BYTE_OFF_W   = 3;
    localparam int DWORD_LSB    = 3;

    function automatic int index_lsb(input int block_offset);
        return DWORD_LSB + block_offset;
    endfunction

    function automatic int way_w(input int num_ways);
        return (num_ways > 1) ? $clog2(num_ways) : 1;
    endfunction

    function automatic logic [63:0] size_mask(input size_e size);
        case (size)
            SIZE_B:  return 64'h0000_0000_0000_00FF;
            SIZE_H:  return 64'h0000_0000_0000_FFFF;
            SIZE_W:  return 64'h0000_0000_FFFF_FFFF;
            SIZE_D:  return 64'hFFFF_FFFF_FFFF_FFFF;
            default: return 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] byte_off, input size_e size);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return byte_off[0];
            SIZE_W:  return |byte_off[1:0];
            SIZE_D:  return |byte_off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_dcache_plru.sv
// Per-set tree pseudo-LRU. Way bit 0 selects at the root, so each node bit
// read on the lookup walk is directly the next bit of the victim way.
module core_dcache_plru
    import core_dcache_pkg::*;
#(
    parameter int NUM_WAYS    = 2,
    parameter int INDEX_WIDTH = 7
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_upd_en,
    input  logic [INDEX_WIDTH-1:0]     i_upd_index,
    input  logic [way_w(NUM_WAYS)-1:0] i_upd_way,
    input  logic [INDEX_WIDTH-1:0]     i_lkp_index,
    output logic [way_w(NUM_WAYS)-1:0] o_lkp_way
);

    localparam int WAY_W = way_w(NUM_WAYS);
    localparam int SETS  = 2 ** INDEX_WIDTH;

    generate
        if (NUM_WAYS == 1) begin : g_single
            logic unused_s;
            assign unused_s  = ^{i_clk, i_rst_n, i_upd_en, i_upd_index, i_upd_way, i_lkp_index};
            assign o_lkp_way = {WAY_W{1'b0}};
        end else begin : g_tree
            localparam int NODES = NUM_WAYS - 1;

            logic [NODES-1:0] tree_q [SETS];
            logic [NODES-1:0] tree_d;
            logic [NODES-1:0] lkp_row_s;

            // Walk root to leaf along the accessed way, pointing each node away from it
            always_comb begin
                int node;
                tree_d = tree_q[i_upd_index];
                node   = 0;
                for (int l = 0; l < WAY_W; l++) begin
                    for (int n = 0; n < NODES; n++) begin
                        tree_d[n] = (n == node) ? ~i_upd_way[l] : tree_d[n];
                    end
                    node = 2 * node + 1 + (i_upd_way[l] ? 1 : 0);
                end
            end

            // Follow the node bits from the root to find the replacement way
            always_comb begin
                int   node;
                logic lkp_bit;
                lkp_row_s = tree_q[i_lkp_index];
                o_lkp_way = {WAY_W{1'b0}};
                node      = 0;
                for (int l = 0; l < WAY_W; l++) begin
                    lkp_bit = 1'b0;
                    for (int n = 0; n < NODES; n++) begin
                        lkp_bit = lkp_bit | ((n == node) && lkp_row_s[n]);
                    end
                    o_lkp_way[l] = lkp_bit;
                    node = 2 * node + 1 + (lkp_bit ? 1 : 0);
                end
            end

            // PLRU state per set, cleared by reset
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    for (int s = 0; s < SETS; s++) begin
                        tree_q[s] <= {NODES{1'b0}};
                    end
                end else if (i_upd_en) begin
                    tree_q[i_upd_index] <= tree_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/core_dcache_way_array.sv
// Data-cache way array: line storage with fill/store/load/evict ports and
// per-set pseudo-LRU replacement hint.
module core_dcache_way_array
    import core_dcache_pkg::*;
#(
    parameter int NUM_WAYS        = 2,
    parameter int INDEX_WIDTH     = 7,
    parameter int BLOCK_OFFSET    = 2,
    parameter int CORE_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 64,
    parameter int AXI_DATA_WIDTH  = 256
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_WIDTH-1:0]      i_addr,
    input  logic [1:0]                 i_size,
    input  logic [CORE_DATA_WIDTH-1:0] i_wr_data,
    input  logic                       i_rd_en,
    input  logic                       i_wr_en,
    input  logic                       i_fill_en,
    input  logic                       i_evict_en,
    input  logic [way_w(NUM_WAYS)-1:0] i_way_sel,
    input  logic [AXI_DATA_WIDTH-1:0]  i_fill_block,
    output logic [CORE_DATA_WIDTH-1:0] o_rd_data,
    output logic                       o_rd_valid,
    output logic [AXI_DATA_WIDTH-1:0]  o_victim_block,
    output logic                       o_victim_valid,
    output logic [way_w(NUM_WAYS)-1:0] o_lru_way,
    output logic                       o_misaligned
);

    localparam int WAY_W   = way_w(NUM_WAYS);
    localparam int SETS    = 2 ** INDEX_WIDTH;
    localparam int IDX_LSB = index_lsb(BLOCK_OFFSET);
    localparam int OFF_W   = BLOCK_OFFSET + BYTE_OFF_W;
    localparam int SHIFT_W = OFF_W + 3;

    logic [AXI_DATA_WIDTH-1:0]  mem_q [NUM_WAYS][SETS];
    logic [AXI_DATA_WIDTH-1:0]  line_d;
    logic                       line_we_s;

    logic [WAY_W-1:0]           way_s;
    logic [INDEX_WIDTH-1:0]     index_s;
    logic [SHIFT_W-1:0]         bit_off_s;
    size_e                      size_s;
    logic                       mis_s;
    logic                       fill_s;
    logic                       wr_s;
    logic                       rd_s;
    logic                       plru_upd_s;
    logic [AXI_DATA_WIDTH-1:0]  line_s;
    logic [AXI_DATA_WIDTH-1:0]  wmask_s;
    logic [AXI_DATA_WIDTH-1:0]  wdata_s;
    logic [CORE_DATA_WIDTH-1:0] mask_s;
    logic [CORE_DATA_WIDTH-1:0] rd_word_s;

    logic [CORE_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                       rd_valid_q, rd_valid_d;
    logic [AXI_DATA_WIDTH-1:0]  victim_q, victim_d;
    logic                       victim_valid_q, victim_valid_d;
    logic                       mis_q, mis_d;
    logic                       unused_s;

    assign way_s     = (NUM_WAYS > 1) ? i_way_sel : {WAY_W{1'b0}};
    assign index_s   = i_addr[IDX_LSB +: INDEX_WIDTH];
    assign bit_off_s = {i_addr[OFF_W-1:0], 3'b000};
    assign size_s    = size_e'(i_size);
    assign mis_s     = is_misaligned(i_addr[BYTE_OFF_LSB +: BYTE_OFF_W], size_s);
    assign line_s    = mem_q[way_s][index_s];
    assign unused_s  = ^{i_addr[ADDR_WIDTH-1:IDX_LSB+INDEX_WIDTH], i_way_sel};

    // Arbitrate fill > store > load and build the merged line and load word
    always_comb begin
        fill_s     = i_fill_en;
        wr_s       = i_wr_en & ~i_fill_en;
        rd_s       = i_rd_en & ~i_fill_en & ~i_wr_en;
        mask_s     = CORE_DATA_WIDTH'(size_mask(size_s));
        wmask_s    = AXI_DATA_WIDTH'(mask_s) << bit_off_s;
        wdata_s    = AXI_DATA_WIDTH'(i_wr_data & mask_s) << bit_off_s;
        rd_word_s  = CORE_DATA_WIDTH'(line_s >> bit_off_s) & mask_s;
        line_we_s  = fill_s | (wr_s & ~mis_s);
        plru_upd_s = fill_s | ((wr_s | rd_s) & ~mis_s);
        if (fill_s) begin
            line_d = i_fill_block;
        end else begin
            line_d = (line_s & ~wmask_s) | (wdata_s & wmask_s);
        end
    end

    // Next values of the response registers; data outputs hold when idle
    always_comb begin
        rd_valid_d     = rd_s;
        mis_d          = (wr_s | rd_s) & mis_s;
        victim_valid_d = i_evict_en;
        if (rd_s) begin
            rd_data_d = mis_s ? {CORE_DATA_WIDTH{1'b0}} : rd_word_s;
        end else begin
            rd_data_d = rd_data_q;
        end
        if (i_evict_en) begin
            victim_d = line_s;
        end else begin
            victim_d = victim_q;
        end
    end

    // Line storage; the victim path reads line_s before this edge commits
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    mem_q[w][s] <= {AXI_DATA_WIDTH{1'b0}};
                end
            end
        end else if (line_we_s) begin
            mem_q[way_s][index_s] <= line_d;
        end
    end

    // Response registers
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rd_data_q      <= {CORE_DATA_WIDTH{1'b0}};
            rd_valid_q     <= 1'b0;
            victim_q       <= {AXI_DATA_WIDTH{1'b0}};
            victim_valid_q <= 1'b0;
            mis_q          <= 1'b0;
        end else begin
            rd_data_q      <= rd_data_d;
            rd_valid_q     <= rd_valid_d;
            victim_q       <= victim_d;
            victim_valid_q <= victim_valid_d;
            mis_q          <= mis_d;
        end
    end

    core_dcache_plru #(
        .NUM_WAYS    (NUM_WAYS),
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_plru (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_upd_en    (plru_upd_s),
        .i_upd_index (index_s),
        .i_upd_way   (way_s),
        .i_lkp_index (index_s),
        .o_lkp_way   (o_lru_way)
    );

    assign o_rd_data      = rd_data_q;
    assign o_rd_valid     = rd_valid_q;
    assign o_victim_block = victim_q;
    assign o_victim_valid = victim_valid_q;
    assign o_misaligned   = mis_q;

endmodule

// File: tb/tb_core_dcache_way_array.sv
// Bench for core_dcache_way_array: directed scenarios plus random traffic
// checked against a byte-array model with a most-recently-used record per set.
module tb_core_dcache_way_array;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [63:0]  addr;
    logic [1:0]   size;
    logic [63:0]  wr_data;
    logic         rd_en, wr_en, fill_en, evict_en;
    logic [0:0]   way_sel;
    logic [255:0] fill_block;
    logic [63:0]  rd_data;
    logic         rd_valid;
    logic [255:0] victim;
    logic         victim_valid;
    logic [0:0]   lru_way;
    logic         mis;

    logic [63:0]  d4_addr;
    logic         d4_rd_en;
    logic [1:0]   d4_way;
    logic [63:0]  d4_rd_data;
    logic         d4_rd_valid;
    logic [255:0] d4_victim;
    logic         d4_victim_valid;
    logic [1:0]   d4_lru;
    logic         d4_mis;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  mdl_mem [2][128][32];
    int          mdl_mru [128];
    logic [63:0] exp_rd;

    core_dcache_way_array dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(addr), .i_size(size), .i_wr_data(wr_data),
        .i_rd_en(rd_en), .i_wr_en(wr_en), .i_fill_en(fill_en), .i_evict_en(evict_en),
        .i_way_sel(way_sel), .i_fill_block(fill_block), .o_rd_data(rd_data),
        .o_rd_valid(rd_valid), .o_victim_block(victim), .o_victim_valid(victim_valid),
        .o_lru_way(lru_way), .o_misaligned(mis)
    );

    core_dcache_way_array #(.NUM_WAYS(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_addr(d4_addr), .i_size(2'b11), .i_wr_data(64'd0),
        .i_rd_en(d4_rd_en), .i_wr_en(1'b0), .i_fill_en(1'b0), .i_evict_en(1'b0),
        .i_way_sel(d4_way), .i_fill_block(256'd0), .o_rd_data(d4_rd_data),
        .o_rd_valid(d4_rd_valid), .o_victim_block(d4_victim), .o_victim_valid(d4_victim_valid),
        .o_lru_way(d4_lru), .o_misaligned(d4_mis)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic f, input logic w, input logic r, input logic e,
                         input logic [0:0] wy, input logic [63:0] a, input logic [1:0] sz,
                         input logic [63:0] wd, input logic [255:0] fb);
        fill_en = f; wr_en = w; rd_en = r; evict_en = e;
        way_sel = wy; addr = a; size = sz; wr_data = wd; fill_block = fb;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 64'd0, 256'd0);
    endtask

    task automatic clear_model();
        for (int w = 0; w < 2; w++)
            for (int s = 0; s < 128; s++)
                for (int b = 0; b < 32; b++) mdl_mem[w][s][b] = 8'h00;
        for (int s = 0; s < 128; s++) mdl_mru[s] = 1;
        exp_rd = 64'd0;
    endtask

    function automatic logic [255:0] mdl_line(input int w, input int s);
        logic [255:0] l;
        for (int b = 0; b < 32; b++) l[8*b +: 8] = mdl_mem[w][s][b];
        return l;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1A8, 2'b11, 64'd0, 256'd0);
        d4_rd_en = 1'b1;
        tick();
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
        n_checks++; if (victim_valid !== 1'b0) begin n_fail++; $display("FAIL reset_victim_valid: got %b expected 0", victim_valid); end
        n_checks++; if (victim !== 256'd0 || d4_victim !== 256'd0) begin n_fail++; $display("FAIL reset_victim: got %h expected 0", victim); end
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL reset_mis: got %b expected 0", mis); end
        rst_n = 1'b1;
        idle();
        d4_rd_en = 1'b0;
        tick();
        n_checks++; if (rd_valid !== 1'b0 || victim_valid !== 1'b0 || d4_rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_response: got rd_valid %b victim_valid %b expected 0 0", rd_valid, victim_valid); end
        n_checks++; if (lru_way !== 1'b0 || d4_lru !== 2'd0) begin n_fail++; $display("FAIL reset_lru: got %0d/%0d expected 0/0", lru_way, d4_lru); end
    endtask

    task automatic test_reset_read();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h1A8, 2'b11, 64'd0, 256'd0);
        tick();
        idle();
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL reset_read_valid: got %b expected 1", rd_valid); end
        n_checks++; if (rd_data !== 64'd0) begin n_fail++; $display("FAIL reset_read_data: got %h expected 0", rd_data); end
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL read_valid_pulse: got %b expected 0", rd_valid); end
    endtask

    task automatic test_byte_merge();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h060, 2'b00, 64'd0, {256{1'b1}});
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h067, 2'b00, 64'h1234_5678_9ABC_DE5A, 256'd0);
        #2;
        n_checks++; if (lru_way !== 1'b1) begin n_fail++; $display("FAIL lru_after_fill: got %0d expected 1", lru_way); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h060, 2'b11, 64'd0, 256'd0);
        tick();
        idle();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 64'h5AFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL byte_merge: got %b %h expected 1 5affffffffffffff", rd_valid, rd_data); end
        tick();
        n_checks++; if (rd_valid !== 1'b0 || rd_data !== 64'h5AFF_FFFF_FFFF_FFFF) begin
            n_fail++; $display("FAIL rd_data_hold: got %b %h expected 0 5affffffffffffff", rd_valid, rd_data); end
    endtask

    task automatic test_misaligned();
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 64'h062, 2'b10, 64'h0000_0000_0000_0000, 256'd0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h060, 2'b10, 64'd0, 256'd0);
        n_checks++; if (mis !== 1'b1 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL mis_write: got mis %b valid %b expected 1 0", mis, rd_valid); end
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h061, 2'b01, 64'd0, 256'd0);
        n_checks++; if (mis !== 1'b0 || rd_valid !== 1'b1 || rd_data !== 64'h0000_0000_FFFF_FFFF) begin
            n_fail++; $display("FAIL mis_write_suppressed: got mis %b %h expected 0 00000000ffffffff", mis, rd_data); end
        tick();
        idle();
        n_checks++; if (mis !== 1'b1 || rd_valid !== 1'b1 || rd_data !== 64'd0) begin
            n_fail++; $display("FAIL mis_read: got mis %b valid %b %h expected 1 1 0", mis, rd_valid, rd_data); end
        tick();
        n_checks++; if (mis !== 1'b0) begin n_fail++; $display("FAIL mis_pulse: got %b expected 0", mis); end
    endtask

    task automatic test_evict_fill();
        logic [255:0] a_line, b_line;
        for (int k = 0; k < 8; k++) begin a_line[32*k +: 32] = $urandom; b_line[32*k +: 32] = $urandom; end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 64'h0A0, 2'b11, 64'd0, a_line);
        tick();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 64'h0A0, 2'b11, 64'd0, b_line);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0B8, 2'b11, 64'd0, 256'd0);
        n_checks++; if (victim_valid !== 1'b1 || victim !== a_line) begin
            n_fail++; $display("FAIL evict_old_line: got %b %h expected 1 %h", victim_valid, victim, a_line); end
        tick();
        idle();
        n_checks++; if (victim_valid !== 1'b0) begin n_fail++; $display("FAIL victim_pulse: got %b expected 0", victim_valid); end
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== b_line[255:192]) begin
            n_fail++; $display("FAIL read_after_fill: got %h expected %h", rd_data, b_line[255:192]); end
    endtask

    task automatic test_plru4();
        for (int w = 0; w < 3; w++) begin
            d4_addr = 64'h120; d4_way = 2'(w); d4_rd_en = 1'b1;
            tick();
        end
        d4_rd_en = 1'b0;
        #2;
        n_checks++; if (d4_lru !== 2'd3) begin n_fail++; $display("FAIL plru4_after_012: got %0d expected 3", d4_lru); end
        n_checks++; if (d4_rd_valid !== 1'b1 || d4_rd_data !== 64'd0 || d4_mis !== 1'b0 || d4_victim_valid !== 1'b0) begin
            n_fail++; $display("FAIL plru4_read_resp: got %b %h expected 1 0", d4_rd_valid, d4_rd_data); end
        d4_way = 2'd3; d4_rd_en = 1'b1;
        tick();
        d4_rd_en = 1'b0;
        #2;
        n_checks++; if (d4_lru !== 2'd0) begin n_fail++; $display("FAIL plru4_after_3: got %0d expected 0", d4_lru); end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 64'h040, 2'b11, 64'd0, {256{1'b1}});
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h040, 2'b11, 64'd0, 256'd0);
        tick();
        n_checks++; if (rd_data !== {64{1'b1}}) begin n_fail++; $display("FAIL pre_reset_read: got %h expected all ones", rd_data); end
        rst_n = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_checks++; if (rd_valid !== 1'b0 || rd_data !== 64'd0) begin
                n_fail++; $display("FAIL reset_mid_read: got %b %h expected 0 0", rd_valid, rd_data); end
        end
        rst_n = 1'b1;
        idle();
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mid_read_after: got %b expected 0", rd_valid); end
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 64'h040, 2'b11, 64'd0, 256'd0);
        tick();
        idle();
        n_checks++; if (rd_valid !== 1'b1 || rd_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_cleared_line: got %b %h expected 1 0", rd_valid, rd_data); end
    endtask

    task automatic test_random();
        logic f, w, r, e, m, exp_rv, exp_mis, exp_vv;
        logic [0:0] wy, exp_lru;
        int idx, dw, by, sz, off;
        logic [63:0] a, wd;
        logic [255:0] fb, exp_vic;
        rst_n = 1'b0;
        idle();
        tick();
        rst_n = 1'b1;
        clear_model();
        for (int it = 0; it < 600; it++) begin
            f  = ($urandom_range(0, 7) == 0);
            w  = ($urandom_range(0, 2) == 0);
            r  = ($urandom_range(0, 1) == 0);
            e  = ($urandom_range(0, 4) == 0);
            wy = 1'($urandom_range(0, 1));
            idx = $urandom_range(0, 3); dw = $urandom_range(0, 3);
            by  = $urandom_range(0, 7); sz = $urandom_range(0, 3);
            a = {$urandom, $urandom};
            a[11:0] = 12'(idx * 32 + dw * 8 + by);
            wd = {$urandom, $urandom};
            for (int k = 0; k < 8; k++) fb[32*k +: 32] = $urandom;
            drive(f, w, r, e, wy, a, 2'(sz), wd, fb);
            #2;
            exp_lru = 1'(1 - mdl_mru[idx]);
            n_checks++; if (lru_way !== exp_lru) begin n_fail++; $display("FAIL rand_lru it %0d: got %0d expected %0d", it, lru_way, exp_lru); end
            off = dw * 8 + by;
            m = (by % (1 << sz)) != 0;
            exp_vv = e;
            exp_vic = mdl_line(wy, idx);
            exp_rv = 1'b0; exp_mis = 1'b0;
            if (f) begin
                for (int k = 0; k < 32; k++) mdl_mem[wy][idx][k] = fb[8*k +: 8];
                mdl_mru[idx] = wy;
            end else if (w) begin
                exp_mis = m;
                if (!m) begin
                    for (int k = 0; k < (1 << sz); k++) mdl_mem[wy][idx][off+k] = wd[8*k +: 8];
                    mdl_mru[idx] = wy;
                end
            end else if (r) begin
                exp_rv = 1'b1; exp_mis = m; exp_rd = 64'd0;
                if (!m) begin
                    for (int k = 0; k < (1 << sz); k++) exp_rd[8*k +: 8] = mdl_mem[wy][idx][off+k];
                    mdl_mru[idx] = wy;
                end
            end
            tick();
            n_checks++; if (rd_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rd_valid it %0d: got %b expected %b", it, rd_valid, exp_rv); end
            n_checks++; if (rd_data !== exp_rd) begin n_fail++; $display("FAIL rand_rd_data it %0d: got %h expected %h", it, rd_data, exp_rd); end
            n_checks++; if (mis !== exp_mis) begin n_fail++; $display("FAIL rand_mis it %0d: got %b expected %b", it, mis, exp_mis); end
            n_checks++; if (victim_valid !== exp_vv) begin n_fail++; $display("FAIL rand_victim_valid it %0d: got %b expected %b", it, victim_valid, exp_vv); end
            if (exp_vv) begin
                n_checks++; if (victim !== exp_vic) begin n_fail++; $display("FAIL rand_victim it %0d: got %h expected %h", it, victim, exp_vic); end
            end
        end
        idle();
    endtask

    initial begin
        d4_addr = 64'd0; d4_rd_en = 1'b0; d4_way = 2'd0;
        test_reset();
        test_reset_read();
        test_byte_merge();
        test_misaligned();
        test_evict_fill();
        test_plru4();
        test_reset_mid_read();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
